time_set_ctrl: RTL and testbench

//   Time-setting mode controller for the digital clock. Consumes single-cycle

---
 rtl/time_set_ctrl.sv | 131 +++++++++++++
 tb/tb_time_set_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting mode controller: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
// Optional idle auto-exit to RUN is enabled by defining SET_TIMEOUT_EN.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_2hz,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    output logic [1:0] sel,
    output logic       run_en,
    output logic       adj_up,
    output logic       adj_dn,
    output logic       sec_clr,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   blink_q, blink_d;
    logic   run_en_q, run_en_d;
    logic   adj_up_q, adj_up_d;
    logic   adj_dn_q, adj_dn_d;
    logic   sec_clr_q, sec_clr_d;

    logic key_any;
    logic in_set;

    assign key_any = key_inc | key_dec;
    assign in_set  = (state_q != RUN);

`ifdef SET_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT_TICKS + 1);

    logic [IW-1:0] idle_q, idle_d;
    logic [IW-1:0] idle_inc;

    assign idle_inc = idle_q + IW'(1);
`endif

    always_comb begin
        state_d   = state_q;
        blink_d   = blink_q;
        adj_up_d  = 1'b0;
        adj_dn_d  = 1'b0;
        sec_clr_d = 1'b0;
`ifdef SET_TIMEOUT_EN
        idle_d    = idle_q;
`endif
        if (key_mode) begin
            state_d = state_t'(state_q + 2'd1);
            blink_d = 1'b0;
`ifdef SET_TIMEOUT_EN
            idle_d  = '0;
`endif
        end else if (in_set && key_any) begin
            // A simultaneous INC+DEC is still activity, but strobes nothing
            if (key_inc ^ key_dec) begin
                if (state_q == SET_SEC) begin
                    sec_clr_d = 1'b1;
                end else begin
                    adj_up_d = key_inc;
                    adj_dn_d = key_dec;
                end
            end
            blink_d = 1'b0;
`ifdef SET_TIMEOUT_EN
            idle_d  = '0;
`endif
        end else if (in_set && tick_2hz) begin
`ifdef SET_TIMEOUT_EN
            if (idle_inc == IW'(TIMEOUT_TICKS)) begin
                state_d = RUN;
                idle_d  = '0;
            end else begin
                idle_d  = idle_inc;
                blink_d = ~blink_q;
            end
`else
            blink_d = ~blink_q;
`endif
        end
        if (state_d == RUN) begin
            blink_d = 1'b0;
`ifdef SET_TIMEOUT_EN
            idle_d  = '0;
`endif
        end
        run_en_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            blink_q   <= 1'b0;
            run_en_q  <= 1'b1;
            adj_up_q  <= 1'b0;
            adj_dn_q  <= 1'b0;
            sec_clr_q <= 1'b0;
`ifdef SET_TIMEOUT_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            blink_q   <= blink_d;
            run_en_q  <= run_en_d;
            adj_up_q  <= adj_up_d;
            adj_dn_q  <= adj_dn_d;
            sec_clr_q <= sec_clr_d;
`ifdef SET_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    assign sel     = state_q;
    assign run_en  = run_en_q;
    assign adj_up  = adj_up_q;
    assign adj_dn  = adj_dn_q;
    assign sec_clr = sec_clr_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios then random key/tick traffic
// checked against a field-level reference model.
module tb_time_set_ctrl;

`ifdef SET_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 20;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_2hz = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic       key_dec = 1'b0;
    logic [1:0] sel;
    logic       run_en;
    logic       adj_up;
    logic       adj_dn;
    logic       sec_clr;
    logic       blink;

    time_set_ctrl #(.TIMEOUT_TICKS(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_2hz (tick_2hz),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .key_dec  (key_dec),
        .sel      (sel),
        .run_en   (run_en),
        .adj_up   (adj_up),
        .adj_dn   (adj_dn),
        .sec_clr  (sec_clr),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: field index 0=run,1=hour,2=min,3=sec
    int field   = 0;
    int idle    = 0;
    bit m_blink = 0;
    bit e_up    = 0;
    bit e_dn    = 0;
    bit e_clr   = 0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        field   = 0;
        idle    = 0;
        m_blink = 0;
        e_up    = 0;
        e_dn    = 0;
        e_clr   = 0;
    endtask

    task automatic model(input bit m, input bit i, input bit d, input bit t);
        e_up  = 0;
        e_dn  = 0;
        e_clr = 0;
        if (m) begin
            field   = (field + 1) % 4;
            m_blink = 0;
            idle    = 0;
        end else if (field != 0 && (i || d)) begin
            if (i != d) begin
                if (field == 3) e_clr = 1;
                else if (i)     e_up  = 1;
                else            e_dn  = 1;
            end
            m_blink = 0;
            idle    = 0;
        end else if (field != 0 && t) begin
`ifdef SET_TIMEOUT_EN
            idle = idle + 1;
            if (idle == TO) field = 0;
            else m_blink = !m_blink;
`else
            m_blink = !m_blink;
`endif
        end
        if (field == 0) begin
            m_blink = 0;
            idle    = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/sel"},     8'(sel),     8'(field));
        chk({tag, "/run_en"},  8'(run_en),  8'(field == 0));
        chk({tag, "/adj_up"},  8'(adj_up),  8'(e_up));
        chk({tag, "/adj_dn"},  8'(adj_dn),  8'(e_dn));
        chk({tag, "/sec_clr"}, 8'(sec_clr), 8'(e_clr));
        chk({tag, "/blink"},   8'(blink),   8'(m_blink));
    endtask

    task automatic step(input string tag, input bit m, input bit i,
                        input bit d, input bit t);
        key_mode = m;
        key_inc  = i;
        key_dec  = d;
        tick_2hz = t;
        @(posedge clk);
        #1;
        key_mode = 0;
        key_inc  = 0;
        key_dec  = 0;
        tick_2hz = 0;
        model(m, i, d, t);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("rst_hold");
        @(posedge clk);
        #1;
        rst = 0;

        // 1: async reset from SET_MIN
        step("t1_m1", 1, 0, 0, 0);
        step("t1_m2", 1, 0, 0, 0);
        step("t1_tk", 0, 0, 0, 1);
        #2;
        rst = 1;
        #2;
        model_reset();
        check_all("t1_rst");
        @(posedge clk);
        #1;
        rst = 0;
        step("t1_idle", 0, 0, 0, 0);

        // 2: mode sequence
        for (int k = 1; k <= 4; k++) begin
            step("t2_mode", 1, 0, 0, 0);
            chk("t2_sel", 8'(sel), 8'(k % 4));
            chk("t2_run", 8'(run_en), 8'(k == 4));
        end

        // 3: strobes per state
        step("t3_hour", 1, 0, 0, 0);
        step("t3_inc", 0, 1, 0, 0);
        chk("t3_up", 8'(adj_up), 8'd1);
        step("t3_dec", 0, 0, 1, 0);
        chk("t3_dn", 8'(adj_dn), 8'd1);
        chk("t3_up0", 8'(adj_up), 8'd0);
        step("t3_gap", 0, 0, 0, 0);
        step("t3_min", 1, 0, 0, 0);
        step("t3_sec", 1, 0, 0, 0);
        step("t3_sdec", 0, 0, 1, 0);
        chk("t3_clr", 8'(sec_clr), 8'd1);
        chk("t3_dn0", 8'(adj_dn), 8'd0);
        step("t3_run", 1, 0, 0, 0);
        step("t3_rinc", 0, 1, 0, 0);
        chk("t3_rup0", 8'(adj_up), 8'd0);

        // 4: simultaneous keys in SET_MIN
        step("t4_h", 1, 0, 0, 0);
        step("t4_m", 1, 0, 0, 0);
        step("t4_mi", 1, 1, 0, 0);
        chk("t4_sel", 8'(sel), 8'd3);
        chk("t4_up0", 8'(adj_up), 8'd0);
        step("t4_id", 0, 1, 1, 0);
        chk("t4_clr0", 8'(sec_clr), 8'd0);
        step("t4_run", 1, 0, 0, 0);

        // 5: blink in SET_HOUR
        step("t5_h", 1, 0, 0, 0);
        step("t5_t1", 0, 0, 0, 1);
        chk("t5_b1", 8'(blink), 8'd1);
        step("t5_t2", 0, 0, 0, 1);
        chk("t5_b2", 8'(blink), 8'd0);
        step("t5_t3", 0, 0, 0, 1);
        chk("t5_b3", 8'(blink), 8'd1);
        step("t5_inc", 0, 1, 0, 0);
        chk("t5_b0", 8'(blink), 8'd0);
        step("t5_x1", 1, 0, 0, 0);
        step("t5_x2", 1, 0, 0, 0);
        step("t5_x3", 1, 0, 0, 0);

`ifdef SET_TIMEOUT_EN
        // 6: idle timeout and restart on key
        step("t6_h", 1, 0, 0, 0);
        step("t6_m", 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) step("t6_tk", 0, 0, 0, 1);
        chk("t6_hold", 8'(sel), 8'd2);
        step("t6_tk4", 0, 0, 0, 1);
        chk("t6_exit", 8'(sel), 8'd0);
        chk("t6_runen", 8'(run_en), 8'd1);
        step("t6_h2", 1, 0, 0, 0);
        step("t6_m2", 1, 0, 0, 0);
        step("t6_a1", 0, 0, 0, 1);
        step("t6_a2", 0, 0, 0, 1);
        step("t6_key", 0, 1, 0, 1);
        step("t6_a4", 0, 0, 0, 1);
        chk("t6_stay", 8'(sel), 8'd2);
        step("t6_a5", 0, 0, 0, 1);
        step("t6_a6", 0, 0, 0, 1);
        step("t6_a7", 0, 0, 0, 1);
        chk("t6_exit2", 8'(sel), 8'd0);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
